id_stage_pipelined: RTL and testbench

//  Parametrised MIPS instruction-decode stage: decodes opcode, reads register file, detects hazards and registers the ID/EX pipeline latch.
//  - Generalises the decoder: register file, ID/EX latch, load-use stall, flush/bubble insertion and a stall counter.
//  - Optional early branch resolution.
//  - Sits between the IF/ID latch and the EX stage.

---
 rtl/id_stage_pipelined_if.sv | 65 ++++++
 rtl/id_stage_pipelined.sv | 148 ++++++++++++++
 tb/tb_id_stage_pipelined.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipelined_if.sv
// Bundle between the IF/ID latch, WB/EX feedback and the ID/EX latch of the decode stage.
// The slave modport is the decode stage's view; the master modport is the surrounding pipeline's view.
interface id_stage_pipelined_if #(
    parameter int PROC_BITS        = 32,
    parameter int REG_ADDRS_BITS   = 5,
    parameter int INSTRUCTION_BITS = 32,
    parameter int OPCODE_BITS      = 6,
    parameter int STALL_CNT_BITS   = 16
) ();
    localparam int NUM_REGS = 2 ** REG_ADDRS_BITS;

    logic [INSTRUCTION_BITS-1:0]    i_instruction;
    logic [PROC_BITS-1:0]           i_PCNext;
    logic                           i_valid;
    logic                           i_flush;
    logic [PROC_BITS-1:0]           i_write_data;
    logic [REG_ADDRS_BITS-1:0]      i_mem_wb_rd;
    logic                           i_mem_wb_RegWrite;
    logic [REG_ADDRS_BITS-1:0]      i_id_ex_rt;
    logic                           i_id_ex_MemRead;

    logic                           o_PCWrite;
    logic                           o_if_id_write;
    logic                           o_valid;
    logic [PROC_BITS-1:0]           o_PCNext;
    logic [OPCODE_BITS-1:0]         o_opcode;
    logic                           o_RegDst;
    logic                           o_RegWrite;
    logic                           o_MemRead;
    logic                           o_MemWrite;
    logic                           o_MemtoReg;
    logic                           o_ALUSrc;
    logic [3:0]                     o_ALUOp;
    logic [PROC_BITS-1:0]           o_read_data_1;
    logic [PROC_BITS-1:0]           o_read_data_2;
    logic [PROC_BITS-1:0]           o_immediate_data_ext;
    logic [PROC_BITS-1:0]           o_jump_address;
    logic [REG_ADDRS_BITS-1:0]      o_rs;
    logic [REG_ADDRS_BITS-1:0]      o_rt;
    logic [REG_ADDRS_BITS-1:0]      o_rd;
    logic [STALL_CNT_BITS-1:0]      o_stall_count;
    logic [NUM_REGS*PROC_BITS-1:0]  o_rf_regs;
    logic                           o_branch_taken;
    logic [PROC_BITS-1:0]           o_branch_target;

    modport slave (
        input  i_instruction, i_PCNext, i_valid, i_flush, i_write_data,
               i_mem_wb_rd, i_mem_wb_RegWrite, i_id_ex_rt, i_id_ex_MemRead,
        output o_PCWrite, o_if_id_write, o_valid, o_PCNext, o_opcode,
               o_RegDst, o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg,
               o_ALUSrc, o_ALUOp, o_read_data_1, o_read_data_2,
               o_immediate_data_ext, o_jump_address, o_rs, o_rt, o_rd,
               o_stall_count, o_rf_regs, o_branch_taken, o_branch_target
    );

    modport master (
        output i_instruction, i_PCNext, i_valid, i_flush, i_write_data,
               i_mem_wb_rd, i_mem_wb_RegWrite, i_id_ex_rt, i_id_ex_MemRead,
        input  o_PCWrite, o_if_id_write, o_valid, o_PCNext, o_opcode,
               o_RegDst, o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg,
               o_ALUSrc, o_ALUOp, o_read_data_1, o_read_data_2,
               o_immediate_data_ext, o_jump_address, o_rs, o_rt, o_rd,
               o_stall_count, o_rf_regs, o_branch_taken, o_branch_target
    );
endinterface

// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: register file with WB bypass, decoder, load-use stall and ID/EX latch.
// Define ID_BRANCH_RESOLVE_EN to resolve BEQ/BNE in this stage; otherwise the branch outputs are tied to 0.
module id_stage_pipelined #(
    parameter int PROC_BITS        = 32,
    parameter int REG_ADDRS_BITS   = 5,
    parameter int INSTRUCTION_BITS = 32,
    parameter int OPCODE_BITS      = 6,
    parameter int STALL_CNT_BITS   = 16
) (
    input logic             clk,
    input logic             rst,
    id_stage_pipelined_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_ADDRS_BITS;

    localparam logic [OPCODE_BITS-1:0] OP_RFORMAT = OPCODE_BITS'(6'b000000);
    localparam logic [OPCODE_BITS-1:0] OP_LW      = OPCODE_BITS'(6'b100011);
    localparam logic [OPCODE_BITS-1:0] OP_SW      = OPCODE_BITS'(6'b101011);
    localparam logic [OPCODE_BITS-1:0] OP_ADDI    = OPCODE_BITS'(6'b001000);
    localparam logic [OPCODE_BITS-1:0] OP_BEQ     = OPCODE_BITS'(6'b000100);
    localparam logic [OPCODE_BITS-1:0] OP_BNE     = OPCODE_BITS'(6'b000101);
    localparam logic [OPCODE_BITS-1:0] OP_J       = OPCODE_BITS'(6'b000010);

    logic [PROC_BITS-1:0]      rf [NUM_REGS];
    logic [OPCODE_BITS-1:0]    opcode;
    logic [REG_ADDRS_BITS-1:0] rs, rt, rd;
    logic [PROC_BITS-1:0]      imm_ext, jump_addr, rd1, rd2;
    logic                      reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [3:0]                alu_op;
    logic                      wb_active, hz, bubble;

    assign opcode    = bus.i_instruction[INSTRUCTION_BITS-1 -: OPCODE_BITS];
    assign rs        = bus.i_instruction[21 +: REG_ADDRS_BITS];
    assign rt        = bus.i_instruction[16 +: REG_ADDRS_BITS];
    assign rd        = bus.i_instruction[11 +: REG_ADDRS_BITS];
    assign imm_ext   = {{(PROC_BITS-16){bus.i_instruction[15]}}, bus.i_instruction[15:0]};
    assign jump_addr = {bus.i_PCNext[PROC_BITS-1 -: 4], bus.i_instruction[25:0], 2'b00};

    // A same-cycle WB write to the register being read wins over the stored value.
    assign wb_active = bus.i_mem_wb_RegWrite && (bus.i_mem_wb_rd != '0);
    assign rd1 = (wb_active && bus.i_mem_wb_rd == rs) ? bus.i_write_data : rf[rs];
    assign rd2 = (wb_active && bus.i_mem_wb_rd == rt) ? bus.i_write_data : rf[rt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) rf[k] <= '0;
        end else if (wb_active) begin
            rf[bus.i_mem_wb_rd] <= bus.i_write_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rf_view
        assign bus.o_rf_regs[g*PROC_BITS +: PROC_BITS] = rf[g];
    end

    always_comb begin
        {reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src} = 6'b000000;
        alu_op = 4'h0;
        case (opcode)
            OP_RFORMAT: begin {reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src} = 6'b110000; alu_op = 4'h0; end
            OP_LW:      begin {reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src} = 6'b011011; alu_op = 4'h1; end
            OP_SW:      begin {reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src} = 6'b000101; alu_op = 4'h1; end
            OP_ADDI:    begin {reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src} = 6'b010001; alu_op = 4'h1; end
            OP_BEQ:     alu_op = 4'h2;
            OP_BNE:     alu_op = 4'h2;
            OP_J:       alu_op = 4'hF;
            default:    alu_op = 4'h0;
        endcase
    end

    // LW, ADDI and J never read rt as a source, so a matching rt alone does not stall them.
    assign hz = bus.i_valid && bus.i_id_ex_MemRead && (bus.i_id_ex_rt != '0) &&
                ((bus.i_id_ex_rt == rs) ||
                 ((bus.i_id_ex_rt == rt) && opcode != OP_LW && opcode != OP_ADDI && opcode != OP_J));
    assign bubble = bus.i_flush || hz;

    assign bus.o_PCWrite     = !hz || bus.i_flush;
    assign bus.o_if_id_write = !hz || bus.i_flush;

`ifdef ID_BRANCH_RESOLVE_EN
    assign bus.o_branch_taken  = bus.i_valid && !hz && !bus.i_flush &&
                                 ((opcode == OP_BEQ && rd1 == rd2) || (opcode == OP_BNE && rd1 != rd2));
    assign bus.o_branch_target = bus.i_PCNext + (imm_ext << 2);
`else
    assign bus.o_branch_taken  = 1'b0;
    assign bus.o_branch_target = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_stall_count <= '0;
        end else if (hz && !bus.i_flush && bus.o_stall_count != '1) begin
            bus.o_stall_count <= bus.o_stall_count + 1'b1;
        end
    end

    // Data fields load every cycle; only the controls and valid are squashed for a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_valid              <= 1'b0;
            bus.o_PCNext             <= '0;
            bus.o_opcode             <= '0;
            bus.o_RegDst             <= 1'b0;
            bus.o_RegWrite           <= 1'b0;
            bus.o_MemRead            <= 1'b0;
            bus.o_MemWrite           <= 1'b0;
            bus.o_MemtoReg           <= 1'b0;
            bus.o_ALUSrc             <= 1'b0;
            bus.o_ALUOp              <= 4'h0;
            bus.o_read_data_1        <= '0;
            bus.o_read_data_2        <= '0;
            bus.o_immediate_data_ext <= '0;
            bus.o_jump_address       <= '0;
            bus.o_rs                 <= '0;
            bus.o_rt                 <= '0;
            bus.o_rd                 <= '0;
        end else begin
            bus.o_PCNext             <= bus.i_PCNext;
            bus.o_opcode             <= opcode;
            bus.o_read_data_1        <= rd1;
            bus.o_read_data_2        <= rd2;
            bus.o_immediate_data_ext <= imm_ext;
            bus.o_jump_address       <= jump_addr;
            bus.o_rs                 <= rs;
            bus.o_rt                 <= rt;
            bus.o_rd                 <= rd;
            if (bubble) begin
                bus.o_valid    <= 1'b0;
                bus.o_RegDst   <= 1'b0;
                bus.o_RegWrite <= 1'b0;
                bus.o_MemRead  <= 1'b0;
                bus.o_MemWrite <= 1'b0;
                bus.o_MemtoReg <= 1'b0;
                bus.o_ALUSrc   <= 1'b0;
                bus.o_ALUOp    <= 4'h0;
            end else begin
                bus.o_valid    <= bus.i_valid;
                bus.o_RegDst   <= reg_dst;
                bus.o_RegWrite <= reg_write;
                bus.o_MemRead  <= mem_read;
                bus.o_MemWrite <= mem_write;
                bus.o_MemtoReg <= mem_to_reg;
                bus.o_ALUSrc   <= alu_src;
                bus.o_ALUOp    <= alu_op;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: directed scenarios plus randomized traffic
// compared against a behavioural model of the decode stage.
module tb_id_stage_pipelined;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;

    logic [31:0] mRf [32];
    int unsigned mStall;

    always #5 clk = ~clk;

    id_stage_pipelined_if #(.PROC_BITS(32), .REG_ADDRS_BITS(5), .INSTRUCTION_BITS(32),
                            .OPCODE_BITS(6), .STALL_CNT_BITS(16)) bus ();

    id_stage_pipelined #(.PROC_BITS(32), .REG_ADDRS_BITS(5), .INSTRUCTION_BITS(32),
                         .OPCODE_BITS(6), .STALL_CNT_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Control table as {RegDst,RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,ALUOp}.
    function automatic logic [9:0] refControls(input logic [5:0] op);
        case (op)
            6'b000000: return {6'b110000, 4'h0};
            6'b100011: return {6'b011011, 4'h1};
            6'b101011: return {6'b000101, 4'h1};
            6'b001000: return {6'b010001, 4'h1};
            6'b000100: return {6'b000000, 4'h2};
            6'b000101: return {6'b000000, 4'h2};
            6'b000010: return {6'b000000, 4'hF};
            default:   return 10'd0;
        endcase
    endfunction

    function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] low);
        return {op, rs, rt, low};
    endfunction

    task automatic resetModel();
        for (int k = 0; k < 32; k++) mRf[k] = 32'd0;
        mStall = 0;
    endtask

    // Drives one cycle from the current negedge, checks comb then registered outputs, ends at the next negedge.
    task automatic applyStimulus();
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] instr, pcn, rd1, rd2, immExt, jaddr, expTarget;
        logic        wbHit, hz, flush, valid, expTaken;
        logic [9:0]  ctl, gotCtl;
        instr = bus.i_instruction;
        pcn   = bus.i_PCNext;
        flush = bus.i_flush;
        valid = bus.i_valid;
        op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
        wbHit  = bus.i_mem_wb_RegWrite && bus.i_mem_wb_rd != 5'd0;
        rd1    = (wbHit && bus.i_mem_wb_rd == rs) ? bus.i_write_data : mRf[rs];
        rd2    = (wbHit && bus.i_mem_wb_rd == rt) ? bus.i_write_data : mRf[rt];
        immExt = 32'($signed(instr[15:0]));
        jaddr  = {pcn[31:28], instr[25:0], 2'b00};
        hz = valid && bus.i_id_ex_MemRead && bus.i_id_ex_rt != 5'd0 &&
             (bus.i_id_ex_rt == rs ||
              (bus.i_id_ex_rt == rt && op != 6'b100011 && op != 6'b001000 && op != 6'b000010));
`ifdef ID_BRANCH_RESOLVE_EN
        expTaken  = valid && !hz && !flush && ((op == 6'b000100 && rd1 == rd2) || (op == 6'b000101 && rd1 != rd2));
        expTarget = pcn + (immExt << 2);
`else
        expTaken  = 1'b0;
        expTarget = 32'd0;
`endif
        #1;
        checkOutput("PCWrite", bus.o_PCWrite, !hz || flush);
        checkOutput("if_id_write", bus.o_if_id_write, !hz || flush);
        checkOutput("branch_taken", bus.o_branch_taken, expTaken);
        checkOutput("branch_target", bus.o_branch_target, expTarget);

        @(posedge clk);
        #1;
        if (hz && !flush && mStall != 32'hFFFF) mStall++;
        if (wbHit) mRf[bus.i_mem_wb_rd] = bus.i_write_data;
        ctl    = (flush || hz) ? 10'd0 : refControls(op);
        gotCtl = {bus.o_RegDst, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite,
                  bus.o_MemtoReg, bus.o_ALUSrc, bus.o_ALUOp};
        checkOutput("valid", bus.o_valid, (flush || hz) ? 1'b0 : valid);
        checkOutput("controls", gotCtl, ctl);
        checkOutput("stall_count", bus.o_stall_count, mStall);
        if (!(flush || hz)) begin
            checkOutput("opcode", bus.o_opcode, op);
            checkOutput("read_data_1", bus.o_read_data_1, rd1);
            checkOutput("read_data_2", bus.o_read_data_2, rd2);
            checkOutput("imm_ext", bus.o_immediate_data_ext, immExt);
            checkOutput("jump_address", bus.o_jump_address, jaddr);
            checkOutput("PCNext", bus.o_PCNext, pcn);
            checkOutput("fields", {bus.o_rs, bus.o_rt, bus.o_rd}, {rs, rt, rd});
        end
        checkOutput("rf_written", bus.o_rf_regs[bus.i_mem_wb_rd*32 +: 32], mRf[bus.i_mem_wb_rd]);
        checkOutput("rf_r0", bus.o_rf_regs[31:0], 32'd0);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        bus.i_instruction     = mkInstr(6'b111111, 5'd0, 5'd0, 16'd0);
        bus.i_PCNext          = 32'd0;
        bus.i_valid           = 1'b1;
        bus.i_flush           = 1'b0;
        bus.i_write_data      = 32'd0;
        bus.i_mem_wb_rd       = 5'd0;
        bus.i_mem_wb_RegWrite = 1'b0;
        bus.i_id_ex_rt        = 5'd0;
        bus.i_id_ex_MemRead   = 1'b0;
    endtask

    task automatic randomStimulus();
        logic [5:0] ops [8];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000101, 6'b000010, 6'b110011};
        bus.i_instruction     = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        bus.i_PCNext          = $urandom;
        bus.i_valid           = ($urandom_range(0, 7) != 0);
        bus.i_flush           = ($urandom_range(0, 7) == 0);
        bus.i_write_data      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        bus.i_mem_wb_rd       = 5'($urandom_range(0, 7));
        bus.i_mem_wb_RegWrite = ($urandom_range(0, 1) == 1);
        bus.i_id_ex_rt        = 5'($urandom_range(0, 7));
        bus.i_id_ex_MemRead   = ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        resetModel();
        idleInputs();
        #12;
        checkOutput("reset_valid", bus.o_valid, 1'b0);
        checkOutput("reset_stall", bus.o_stall_count, 16'd0);
        checkOutput("reset_ctl", {bus.o_RegWrite, bus.o_MemRead, bus.o_ALUOp}, 6'd0);
        checkOutput("reset_rd1", bus.o_read_data_1, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            idleInputs();
            bus.i_mem_wb_RegWrite = 1'b1;
            bus.i_mem_wb_rd       = 5'(i);
            bus.i_write_data      = 32'(i * 10);
            applyStimulus();
        end
        for (int i = 0; i < 32; i++) begin
            idleInputs();
            bus.i_instruction = mkInstr(6'b000000, 5'(i), 5'(i), 16'h0020);
            applyStimulus();
            checkOutput("t1_rd1", bus.o_read_data_1, (i == 0) ? 32'd0 : 32'(i * 10));
            checkOutput("t1_rd2", bus.o_read_data_2, (i == 0) ? 32'd0 : 32'(i * 10));
        end

        idleInputs();
        bus.i_mem_wb_RegWrite = 1'b1;
        bus.i_mem_wb_rd       = 5'd5;
        bus.i_write_data      = 32'd77;
        bus.i_instruction     = mkInstr(6'b000000, 5'd5, 5'd0, 16'h0020);
        applyStimulus();
        checkOutput("t2_bypass", bus.o_read_data_1, 32'd77);

        idleInputs();
        bus.i_id_ex_MemRead = 1'b1;
        bus.i_id_ex_rt      = 5'd3;
        bus.i_instruction   = mkInstr(6'b000000, 5'd3, 5'd4, 16'h2820);
        #1;
        checkOutput("t3_PCWrite", bus.o_PCWrite, 1'b0);
        checkOutput("t3_if_id_write", bus.o_if_id_write, 1'b0);
        applyStimulus();
        checkOutput("t3_valid", bus.o_valid, 1'b0);
        checkOutput("t3_stall", bus.o_stall_count, 16'd1);

        bus.i_flush = 1'b1;
        #1;
        checkOutput("t4_PCWrite", bus.o_PCWrite, 1'b1);
        applyStimulus();
        checkOutput("t4_valid", bus.o_valid, 1'b0);
        checkOutput("t4_stall", bus.o_stall_count, 16'd1);

        idleInputs();
        bus.i_instruction = mkInstr(6'b001000, 5'd1, 5'd2, 16'd28089);
        applyStimulus();
        checkOutput("t5_imm_pos", bus.o_immediate_data_ext, 32'h00006DB9);
        bus.i_instruction = mkInstr(6'b001000, 5'd1, 5'd2, 16'hFFC2);
        applyStimulus();
        checkOutput("t5_imm_neg", bus.o_immediate_data_ext, 32'hFFFFFFC2);
        bus.i_instruction = {6'b000010, 26'h000000B};
        applyStimulus();
        checkOutput("t5_jump", bus.o_jump_address, 32'h0000002C);

        idleInputs();
        bus.i_mem_wb_RegWrite = 1'b1;
        bus.i_mem_wb_rd       = 5'd2;
        bus.i_write_data      = 32'd10;
        applyStimulus();
        idleInputs();
        bus.i_PCNext      = 32'd8;
        bus.i_instruction = mkInstr(6'b000100, 5'd1, 5'd2, 16'd4);
`ifdef ID_BRANCH_RESOLVE_EN
        #1;
        checkOutput("t6_beq_taken", bus.o_branch_taken, 1'b1);
        checkOutput("t6_beq_target", bus.o_branch_target, 32'd24);
`endif
        applyStimulus();
        bus.i_instruction = mkInstr(6'b000101, 5'd1, 5'd2, 16'd4);
        applyStimulus();

        for (int n = 0; n < 400; n++) begin
            randomStimulus();
            applyStimulus();
        end

        // Reset asserted mid-stall must clear everything; decoding resumes on the next cycle.
        idleInputs();
        bus.i_id_ex_MemRead = 1'b1;
        bus.i_id_ex_rt      = 5'd6;
        bus.i_instruction   = mkInstr(6'b000000, 5'd6, 5'd0, 16'h0020);
        applyStimulus();
        #2;
        rst = 1'b1;
        #1;
        resetModel();
        checkOutput("midrst_stall", bus.o_stall_count, 16'd0);
        checkOutput("midrst_valid", bus.o_valid, 1'b0);
        checkOutput("midrst_rf5", bus.o_rf_regs[5*32 +: 32], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        bus.i_instruction = mkInstr(6'b100011, 5'd1, 5'd2, 16'd8);
        applyStimulus();
        checkOutput("postrst_valid", bus.o_valid, 1'b1);
        for (int n = 0; n < 40; n++) begin
            randomStimulus();
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
